config_loader: RTL and testbench
================================

Name: config_loader

Overview:
Byte-stream configuration controller that drives the config_en/config_data write ports of an array of logic blocks. It accepts a framed byte stream over a valid/ready handshake and assembles each frame into a 32-bit configuration word. It then issues a one-cycle write strobe to the addressed block. It sits between the external bitstream source and the fabric's logic_block instances.

Parameters:
NUM_BLOCKS, 4, number of addressable logic blocks; width of the one-hot config_en output (1..255).
CNT_W, 8, width of the words_written counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  input byte valid.
in_data  input  8  input byte.
in_ready  output  1  loader can accept a byte this cycle.
restart  input  1  abort or leave the terminal state and return to IDLE.
config_en  output  NUM_BLOCKS  one-hot write strobe, one bit per block.
config_data  output  32  configuration word shared by all blocks.
done  output  1  end-of-bitstream frame received.
error  output  1  framing or address error detected.
words_written  output  CNT_W  count of completed block writes, saturating.

Behaviour:
- Reset: rst is asynchronous, active-low. While rst=0, all outputs take their reset values: state=IDLE, in_ready=0, config_en=0, config_data=32'h0, done=0, error=0, words_written=0. The byte counter also clears. From the first clock after release, the block is in IDLE with in_ready=1.
- Handshake: a byte is consumed on a rising edge where in_valid & in_ready. in_ready=1 only in IDLE, ADDR and DATA. in_ready is a function of state only, never of in_valid.
- Frame format: SYNC byte 8'hA5, then ADDR byte, then 4 DATA bytes, least-significant byte first.
- End frame: SYNC followed by ADDR=8'hFF. An end frame carries no data bytes.
- FSM states and transitions:
  - IDLE: byte==A5 -> ADDR. Any other byte -> ERR.
  - ADDR: byte==FF -> DONE. byte<NUM_BLOCKS -> latch address, clear byte count, go to DATA. Otherwise -> ERR.
  - DATA: each accepted byte is written into config_data[8*cnt +: 8] and cnt increments. After the 4th byte (cnt==3) -> WRITE.
  - WRITE: lasts exactly one cycle. config_en[addr]=1 and all other bits are 0. words_written increments, saturating at all-ones. Next state is IDLE.
  - DONE: done=1. Held until restart or reset.
  - ERR: error=1. Held until restart or reset. No writes are issued.
- Latency: config_en is asserted in the cycle immediately after the edge that consumes the 4th data byte.
- config_data changes only while bytes are consumed in DATA, so it is stable during and after the WRITE strobe. Partially assembled bytes are visible on config_data, but config_en=0 throughout assembly.
- Gaps in in_valid are allowed in any receiving state. State and byte count hold during a gap, with no timeout.
- restart (synchronous, level):
  - In any state, restart=1 forces next state to IDLE and clears cnt, done and error.
  - A byte presented in that same cycle is not consumed: in_ready is forced to 0 while restart=1.
  - restart in DATA aborts the frame and no write occurs. restart during WRITE still completes that cycle's strobe.
  - restart does not clear config_data or words_written.
- Async reset mid-frame discards the partial frame immediately. config_en drops to 0 asynchronously.
- At most one bit of config_en is ever high, and never for more than one consecutive cycle.

Test Plan:
1. Reset release, then stream A5,02,03,00,00,00 with in_valid held high. Required: in_ready high for 6 cycles. Next cycle config_en=4'b0100 and config_data=32'h00000003 for exactly one cycle. words_written=1. in_ready=0 in the WRITE cycle.
2. Back-to-back frames A5,00,01,00,00,00 then A5,01,EF,BE,AD,DE, then end frame A5,FF. Required: config_en=0001 with data 32'h1, then config_en=0010 with data 32'hDEADBEEF. Then done=1, in_ready=0, words_written=2.
3. Bad sync byte 3C from IDLE -> error=1, in_ready=0, no config_en activity. Then restart pulse -> error=0, in_ready=1. A valid frame afterwards writes normally.
4. Address out of range: A5,04 with NUM_BLOCKS=4 -> error=1 with no write. Repeat with address 8'hFE -> error=1.
5. Stream A5,03,11,22 with in_valid gaps of 1-3 cycles, then restart -> no config_en pulse, state IDLE. config_data retains 32'h00002211 in its low bytes.
6. Assert rst=0 asynchronously during a DATA byte, then release -> all outputs at reset values including words_written=0 and config_data=0. No config_en glitch while reset is asserted.

Source files
------------

// File: rtl/config_loader.sv
// Byte-stream configuration loader: parses SYNC/ADDR/4xDATA frames and issues a
// one-cycle one-hot write strobe with the assembled 32-bit word.
module config_loader #(
  parameter int NUM_BLOCKS = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  restart,
  output logic [NUM_BLOCKS-1:0] config_en,
  output logic [31:0]           config_data,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      words_written
);

  localparam logic [8:0] NB = NUM_BLOCKS[8:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state, state_nxt;
  logic       live;
  logic [7:0] addr;
  logic [1:0] cnt;
  logic       take;

  // live keeps in_ready low until the first clock after reset release.
  always_comb begin
    in_ready = 1'b0;
    if (live && !restart &&
        (state == S_IDLE || state == S_ADDR || state == S_DATA))
      in_ready = 1'b1;
    take = in_valid & in_ready;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (take) state_nxt = (in_data == 8'hA5) ? S_ADDR : S_ERR;
      S_ADDR:
        if (take) begin
          if (in_data == 8'hFF)           state_nxt = S_DONE;
          else if ({1'b0, in_data} < NB)  state_nxt = S_DATA;
          else                            state_nxt = S_ERR;
        end
      S_DATA:  if (take && cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = state;
    endcase
    if (restart) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      live          <= 1'b0;
      addr          <= '0;
      cnt           <= '0;
      config_data   <= '0;
      words_written <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (state == S_ADDR && take) begin
        addr <= in_data;
        cnt  <= '0;
      end
      if (state == S_DATA && take) begin
        config_data[{cnt, 3'b000} +: 8] <= in_data;
        cnt <= cnt + 2'd1;
      end
      if (restart) cnt <= '0;
      if (state == S_WRITE && words_written != '1)
        words_written <= words_written + 1'b1;
    end
  end

  // Strobe decodes from registered state only, so async reset clears it at once.
  always_comb begin
    config_en = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++)
      config_en[i] = (state == S_WRITE) && (32'(addr) == i);
  end

  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader against a frame-level reference model.
module tb_config_loader;

  localparam int NB  = 4;
  localparam int CW  = 3;
  localparam int CAP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          restart = 1'b0;
  logic          in_ready;
  logic [NB-1:0] config_en;
  logic [31:0]   config_data;
  logic          done;
  logic          error;
  logic [CW-1:0] words_written;

  config_loader #(.NUM_BLOCKS(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .config_en(config_en),
    .config_data(config_data), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the frame in progress plus outcome flags.
  logic [7:0]  frame[$];
  logic [7:0]  stim_q[$];
  bit          m_live, m_done, m_err, m_wr;
  int          m_wr_addr, m_words;
  logic [31:0] m_data;

  function automatic void model_reset();
    frame.delete();
    stim_q.delete();
    m_live = 0; m_done = 0; m_err = 0; m_wr = 0;
    m_wr_addr = 0; m_words = 0; m_data = '0;
  endfunction

  function automatic void gen_frame();
    int r = $urandom_range(0, 19);
    if (r == 0) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      stim_q.push_back(b);
    end else if (r == 1) begin
      stim_q.push_back(8'hA5); stim_q.push_back(8'hFF);
    end else if (r == 2) begin
      stim_q.push_back(8'hA5); stim_q.push_back(8'($urandom_range(NB, 254)));
    end else begin
      stim_q.push_back(8'hA5); stim_q.push_back(8'($urandom_range(0, NB - 1)));
      for (int k = 0; k < 4; k++) stim_q.push_back(8'($urandom_range(0, 255)));
    end
  endfunction

  task automatic check_outputs(input bit exp_ready);
    check("in_ready", in_ready, exp_ready);
    check("config_en", config_en, m_wr ? (32'd1 << m_wr_addr) : 32'd0);
    check("config_data", config_data, m_data);
    check("done", done, m_done);
    check("error", error, m_err);
    check("words_written", words_written, m_words);
  endtask

  // rmode: 0 random restarts, 1 restart only to leave DONE/ERR, 2 forced restart.
  task automatic step(input int rmode, input bit dense);
    bit exp_ready;
    logic [7:0] b;
    int n;
    if (stim_q.size() == 0) gen_frame();
    case (rmode)
      0: restart = (m_done || m_err) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      1: restart = (m_done || m_err) && ($urandom_range(0, 3) == 0);
      default: restart = 1'b1;
    endcase
    in_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
    in_data  = in_valid ? stim_q[0] : 8'($urandom_range(0, 255));
    exp_ready = m_live && !m_done && !m_err && !m_wr && !restart;
    #1 check_outputs(exp_ready);
    if (m_wr) begin
      if (m_words < CAP) m_words++;
      m_wr = 0;
    end
    if (restart) begin
      frame.delete(); m_done = 0; m_err = 0;
    end else if (exp_ready && in_valid) begin
      b = stim_q.pop_front();
      frame.push_back(b);
      n = frame.size();
      if (n >= 3) m_data[8*(n-3) +: 8] = b;
      if (n == 1 && b != 8'hA5) begin
        m_err = 1; frame.delete();
      end else if (n == 2 && b == 8'hFF) begin
        m_done = 1; frame.delete();
      end else if (n == 2 && b >= NB) begin
        m_err = 1; frame.delete();
      end else if (n == 6) begin
        m_wr = 1; m_wr_addr = frame[1]; frame.delete();
      end
    end
    m_live = 1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_config_en"}, config_en, 0);
    check({tag, "_config_data"}, config_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_words"}, words_written, 0);
  endtask

  // Called with rst already low; releases it and takes one idle edge.
  task automatic release_reset();
    in_valid = 1'b0; restart = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    m_live = 1;
  endtask

  logic [7:0] directed[] = '{8'hA5, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00,
                             8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                             8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                             8'hA5, 8'hFF, 8'h3C,
                             8'hA5, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88,
                             8'hA5, 8'h04, 8'hA5, 8'hFE};

  initial begin
    int k;
    #13 check_reset_values("por");
    @(posedge clk);
    release_reset();

    // Directed frames: normal writes, end frame, bad sync, bad addresses.
    foreach (directed[i]) stim_q.push_back(directed[i]);
    for (k = 0; k < 400 && stim_q.size() > 0; k++) step(1, 1);
    if (stim_q.size() > 0) check("directed_bound", 0, 1);
    for (k = 0; k < 20 && !m_err; k++) step(1, 1);
    step(2, 0);

    // Partial frame with gaps, then abort.
    stim_q.delete();
    stim_q.push_back(8'hA5); stim_q.push_back(8'h03);
    stim_q.push_back(8'h11); stim_q.push_back(8'h22);
    for (k = 0; k < 100 && stim_q.size() > 0; k++) step(1, 0);
    if (stim_q.size() > 0) check("gap_bound", 0, 1);
    step(2, 0);
    check("abort_data_lo", config_data[15:0], 16'h2211);
    for (k = 0; k < 4; k++) step(1, 0);

    for (k = 0; k < 1500; k++) step(0, 1'($urandom_range(0, 1)));

    // Async reset while a data byte sequence is in progress.
    for (k = 0; k < 300 && !(frame.size() >= 3); k++) step(1, 0);
    if (frame.size() < 3) check("mid_data_bound", 0, 1);
    #2 rst = 1'b0;
    #1 check_reset_values("rst_data");
    @(posedge clk); #1 check("rst_hold_config_en", config_en, 0);
    release_reset();
    for (k = 0; k < 300; k++) step(0, 1'($urandom_range(0, 1)));

    // Async reset landing in the strobe cycle.
    for (k = 0; k < 300 && !m_wr; k++) step(1, 1);
    if (!m_wr) check("write_bound", 0, 1);
    #1 check("pre_rst_strobe", config_en, 32'd1 << m_wr_addr);
    #1 rst = 1'b0;
    #1 check_reset_values("rst_write");
    release_reset();
    for (k = 0; k < 300; k++) step(0, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
